vga_scan_sync: RTL and testbench

VGA 640x480@60 Hz scan generator and digit snapshot stage that sits directly upstream of the record-display renderer. It derives a 25 MHz pixel tick from the 100 MHz system clock and produces the `hc`/`vc` beam counters, sync pulses and active-video flag. At each frame boundary it latches the seven BCD record digits and the record-valid flag, so the renderer sees values that stay constant for a whole frame and the display does not tear.

---
 rtl/vga_pkg.sv | 19 +
 rtl/pix_tick_gen.sv | 23 ++
 rtl/vga_scan_sync.sv | 102 ++++++++++
 tb/tb_vga_scan_sync.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared 640x480@60 Hz timing constants, also imported by the downstream renderer.
package vga_pkg;

  localparam int unsigned PIX_DIV = 4;
  localparam int unsigned H_TOTAL = 800;
  localparam int unsigned V_TOTAL = 525;
  localparam int unsigned H_SYNC  = 96;
  localparam int unsigned V_SYNC  = 2;
  localparam int unsigned HBP     = 144;
  localparam int unsigned HFP     = 784;
  localparam int unsigned VBP     = 35;
  localparam int unsigned VFP     = 515;

  // A non-decimal nibble would render as garbage, so it is shown as 0.
  function automatic logic [3:0] bcd_fix(input logic [3:0] d);
    return (d > 4'd9) ? 4'd0 : d;
  endfunction

endpackage

// File: rtl/pix_tick_gen.sv
// Clock-enable divider: tick is high for one clock out of every DIV clocks.
module pix_tick_gen #(
  parameter int unsigned DIV = 4
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int unsigned W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] div;

  always_ff @(posedge clk) begin
    if (rst)               div <= '0;
    else if (div == LAST)  div <= '0;
    else                   div <= div + 1'b1;
  end

  assign tick = (div == LAST);

endmodule

// File: rtl/vga_scan_sync.sv
// VGA beam counters, sync decode and per-frame snapshot of the record digits.
module vga_scan_sync
  import vga_pkg::*;
#(
  parameter int unsigned PIX_DIV_P = PIX_DIV,
  parameter int unsigned H_TOTAL_P = H_TOTAL,
  parameter int unsigned V_TOTAL_P = V_TOTAL,
  parameter int unsigned H_SYNC_P  = H_SYNC,
  parameter int unsigned V_SYNC_P  = V_SYNC,
  parameter int unsigned HBP_P     = HBP,
  parameter int unsigned HFP_P     = HFP,
  parameter int unsigned VBP_P     = VBP,
  parameter int unsigned VFP_P     = VFP
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        has_record_in,
  input  logic [27:0] digits_in,
  output logic [9:0]  hc,
  output logic [9:0]  vc,
  output logic        hsync,
  output logic        vsync,
  output logic        video_on,
  output logic        pix_tick,
  output logic        frame_start,
  output logic        has_record,
  output logic [3:0]  led1,
  output logic [3:0]  led2,
  output logic [3:0]  led3,
  output logic [3:0]  led4,
  output logic [3:0]  led5,
  output logic [3:0]  led6,
  output logic [3:0]  led7
);

  logic [9:0] hc_next;
  logic [9:0] vc_next;
  logic       h_end;
  logic       v_end;
  logic       frame_end;

  pix_tick_gen #(.DIV(PIX_DIV_P)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (pix_tick)
  );

  always_comb begin
    h_end     = (hc == 10'(H_TOTAL_P - 1));
    v_end     = (vc == 10'(V_TOTAL_P - 1));
    frame_end = pix_tick && h_end && v_end;
    hc_next   = hc;
    vc_next   = vc;
    if (pix_tick) begin
      if (h_end) begin
        hc_next = '0;
        vc_next = v_end ? 10'd0 : vc + 10'd1;
      end else begin
        hc_next = hc + 10'd1;
      end
    end
  end

  // Sync flags decode the next counter values so they land on the same edge as hc/vc.
  always_ff @(posedge clk) begin
    if (rst) begin
      hc          <= '0;
      vc          <= '0;
      hsync       <= 1'b0;
      vsync       <= 1'b0;
      video_on    <= 1'b0;
      frame_start <= 1'b0;
      has_record  <= 1'b0;
      led1        <= '0;
      led2        <= '0;
      led3        <= '0;
      led4        <= '0;
      led5        <= '0;
      led6        <= '0;
      led7        <= '0;
    end else begin
      hc          <= hc_next;
      vc          <= vc_next;
      hsync       <= !(hc_next < 10'(H_SYNC_P));
      vsync       <= !(vc_next < 10'(V_SYNC_P));
      video_on    <= (hc_next >= 10'(HBP_P)) && (hc_next < 10'(HFP_P)) &&
                     (vc_next >= 10'(VBP_P)) && (vc_next < 10'(VFP_P));
      frame_start <= frame_end;
      if (frame_end) begin
        has_record <= has_record_in;
        led1       <= bcd_fix(digits_in[3:0]);
        led2       <= bcd_fix(digits_in[7:4]);
        led3       <= bcd_fix(digits_in[11:8]);
        led4       <= bcd_fix(digits_in[15:12]);
        led5       <= bcd_fix(digits_in[19:16]);
        led6       <= bcd_fix(digits_in[23:20]);
        led7       <= bcd_fix(digits_in[27:24]);
      end
    end
  end

endmodule

// File: tb/tb_vga_scan_sync.sv
// Bench for vga_scan_sync: a scaled-timing instance for frame behaviour and a
// default-timing instance for the real 640x480 sync positions.
module tb_vga_scan_sync;

  localparam int SD = 4, SHT = 64, SVT = 16, SHS = 8, SVS = 2;
  localparam int SHB = 12, SHF = 60, SVB = 3, SVF = 14;
  localparam int FRAME = SD * SHT * SVT;
  localparam int W = 29;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        has_record_in = 1'b0;
  logic [27:0] digits_in = '0;

  logic [9:0]  d_hc, d_vc, g_hc, g_vc;
  logic        d_hsync, d_vsync, d_video_on, d_pix_tick, d_frame_start, d_has_record;
  logic        g_hsync, g_vsync, g_video_on, g_pix_tick, g_frame_start, g_has_record;
  logic [27:0] d_snap, g_snap;

  always #5 clk = ~clk;

  vga_scan_sync #(
    .PIX_DIV_P(SD), .H_TOTAL_P(SHT), .V_TOTAL_P(SVT), .H_SYNC_P(SHS), .V_SYNC_P(SVS),
    .HBP_P(SHB), .HFP_P(SHF), .VBP_P(SVB), .VFP_P(SVF)
  ) dut (
    .clk(clk), .rst(rst), .has_record_in(has_record_in), .digits_in(digits_in),
    .hc(d_hc), .vc(d_vc), .hsync(d_hsync), .vsync(d_vsync), .video_on(d_video_on),
    .pix_tick(d_pix_tick), .frame_start(d_frame_start), .has_record(d_has_record),
    .led1(d_snap[3:0]), .led2(d_snap[7:4]), .led3(d_snap[11:8]), .led4(d_snap[15:12]),
    .led5(d_snap[19:16]), .led6(d_snap[23:20]), .led7(d_snap[27:24])
  );

  vga_scan_sync dut_full (
    .clk(clk), .rst(rst), .has_record_in(has_record_in), .digits_in(digits_in),
    .hc(g_hc), .vc(g_vc), .hsync(g_hsync), .vsync(g_vsync), .video_on(g_video_on),
    .pix_tick(g_pix_tick), .frame_start(g_frame_start), .has_record(g_has_record),
    .led1(g_snap[3:0]), .led2(g_snap[7:4]), .led3(g_snap[11:8]), .led4(g_snap[15:12]),
    .led5(g_snap[19:16]), .led6(g_snap[23:20]), .led7(g_snap[27:24])
  );

  int n_checks = 0;
  int n_pass = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Reference model of the scaled instance, written from the timing description.
  int          m_div, m_hc, m_vc;
  logic        m_fs, m_hr, started = 1'b0;
  logic [27:0] m_snap;
  int          trace_err = 0;

  function automatic logic [27:0] fix_all(input logic [27:0] x);
    logic [27:0] r;
    for (int i = 0; i < 7; i++) r[i*4 +: 4] = (x[i*4 +: 4] > 4'd9) ? 4'd0 : x[i*4 +: 4];
    return r;
  endfunction

  always @(posedge clk) begin
    started <= 1'b1;
    if (rst) begin
      m_div <= 0; m_hc <= 0; m_vc <= 0; m_fs <= 1'b0; m_hr <= 1'b0; m_snap <= '0;
    end else begin
      m_fs <= 1'b0;
      if (m_div == SD - 1) begin
        m_div <= 0;
        if (m_hc == SHT - 1) begin
          m_hc <= 0;
          if (m_vc == SVT - 1) begin
            m_vc <= 0;
            m_fs <= 1'b1;
            m_hr <= has_record_in;
            m_snap <= fix_all(digits_in);
          end else m_vc <= m_vc + 1;
        end else m_hc <= m_hc + 1;
      end else m_div <= m_div + 1;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      if (d_hc !== 10'(m_hc) || d_vc !== 10'(m_vc) ||
          d_hsync !== (m_hc >= SHS) || d_vsync !== (m_vc >= SVS) ||
          d_video_on !== (m_hc >= SHB && m_hc < SHF && m_vc >= SVB && m_vc < SVF) ||
          d_pix_tick !== (m_div == SD - 1) || d_frame_start !== m_fs ||
          d_has_record !== m_hr || d_snap !== m_snap) begin
        trace_err++;
        if (trace_err == 1)
          $display("trace divergence at %0t: dut hc=%0d vc=%0d model hc=%0d vc=%0d",
                   $time, d_hc, d_vc, m_hc, m_vc);
      end
    end
  end

  task automatic wait_hv(input int h, input int v, output int n);
    n = 0;
    while (!(d_hc == 10'(h) && d_vc == 10'(v)) && n < 2 * FRAME) begin
      @(posedge clk); #1; n++;
    end
    check("wait_hv_reached", (n < 2 * FRAME), 1);
  endtask

  task automatic wait_g_hc(input int h);
    int n = 0;
    while (g_hc != 10'(h) && n < 4000) begin
      @(posedge clk); #1; n++;
    end
    check("wait_g_hc_reached", (n < 4000), 1);
  endtask

  task automatic wait_fs();
    int n = 0;
    while (!d_frame_start && n < 2 * FRAME) begin
      @(posedge clk); #1; n++;
    end
    check("frame_start_seen", (n < 2 * FRAME), 1);
  endtask

  typedef struct {
    logic [27:0] digits;
    logic        hr;
    logic [27:0] exp_digits;
    logic        exp_hr;
  } vec_t;

  vec_t         vecs[4];
  logic [W-1:0] exp_v;
  int           n;

  initial begin
    vecs[0] = '{28'h1234567, 1'b1, 28'h1234567, 1'b1};
    vecs[1] = '{28'h123456B, 1'b1, 28'h1234560, 1'b1};
    vecs[2] = '{28'hFA98F01, 1'b0, 28'h0098001, 1'b0};
    vecs[3] = '{28'h9999999, 1'b1, 28'h9999999, 1'b1};

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_hc", d_hc, 0);
    check("rst_vc", d_vc, 0);
    check("rst_hsync", d_hsync, 0);
    check("rst_vsync", d_vsync, 0);
    check("rst_video_on", d_video_on, 0);
    check("rst_frame_start", d_frame_start, 0);
    check("rst_has_record", d_has_record, 0);
    check("rst_leds", d_snap, 0);
    check("rst_full_hc_vc", {g_hc, g_vc}, 0);
    check("rst_full_flags", {g_hsync, g_vsync, g_video_on, g_frame_start, g_has_record}, 0);
    check("rst_full_leds", g_snap, 0);

    rst = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      check("tick_after_release", g_pix_tick, (k % 4 == 3));
      check("hc_after_release", g_hc, k / 4);
    end

    // Real 640x480 timing: hsync edge at 96, wrap after 799.
    wait_g_hc(95);
    check("full_hsync_at_95", g_hsync, 0);
    wait_g_hc(96);
    check("full_hsync_at_96", g_hsync, 1);
    wait_g_hc(799);
    check("full_vc_at_799", g_vc, 0);
    check("full_video_off_line0", g_video_on, 0);
    wait_g_hc(0);
    check("full_vc_after_wrap", g_vc, 1);
    check("full_hsync_after_wrap", g_hsync, 0);
    check("full_vsync_line1", g_vsync, 0);

    // Scaled instance: hsync edge and active-area edges.
    wait_hv(SHS - 1, SVB, n);
    check("hsync_before_edge", d_hsync, 0);
    wait_hv(SHS, SVB, n);
    check("hsync_at_edge", d_hsync, 1);
    wait_hv(SHB - 1, SVB, n);
    check("video_before_hbp", d_video_on, 0);
    wait_hv(SHB, SVB, n);
    check("video_at_hbp", d_video_on, 1);
    wait_hv(SHF - 1, SVB, n);
    check("video_last_col", d_video_on, 1);
    wait_hv(SHF, SVB, n);
    check("video_at_hfp", d_video_on, 0);

    wait_hv(SHT - 1, 10, n);
    wait_hv(0, 11, n);
    check("line_wrap_latency", n, SD);
    check("line_wrap_hsync", d_hsync, 0);

    // Snapshot vectors: expected pushed when driven, popped on frame_start.
    for (int i = 0; i < 4; i++) begin
      digits_in = vecs[i].digits;
      has_record_in = vecs[i].hr;
      exp_q.push_back({vecs[i].exp_hr, vecs[i].exp_digits});
      wait_fs();
      exp_v = exp_q.pop_front();
      check("snapshot_at_frame", {d_has_record, d_snap}, exp_v);
      check("frame_start_at_origin", {d_hc, d_vc}, 0);
      @(posedge clk); #1;
      check("frame_start_one_clock", d_frame_start, 0);
      wait_hv(0, 8, n);
      digits_in = (i == 0) ? 28'h7654321 : 28'($urandom);
      has_record_in = (i == 0) ? 1'b0 : 1'($urandom_range(0, 1));
      wait_hv(SHT - 1, SVT - 1, n);
      check("snapshot_holds", {d_has_record, d_snap}, exp_v);
    end

    // Mid-frame reset: no frame_start for the restart, divider restarts.
    wait_hv(40, 10, n);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_hc_vc", {d_hc, d_vc}, 0);
    check("midrst_frame_start", d_frame_start, 0);
    check("midrst_tick", d_pix_tick, 0);
    check("midrst_snapshot", {d_has_record, d_snap}, 0);
    check("midrst_flags", {d_hsync, d_vsync, d_video_on}, 0);
    rst = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      check("midrst_tick_after_release", d_pix_tick, (k == 3));
      check("midrst_no_frame_start", d_frame_start, 0);
    end
    check("midrst_hc_after_4", d_hc, 1);

    check("model_trace", trace_err, 0);
    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
